// File: rtl/bcd_subtractor_serial.sv
// Digit-serial packed-BCD subtractor: diff = a - b - bin, one digit per clock, LSD first.
// Negative results come back in ten's complement with bout set; invalid input digits raise err.
module bcd_subtractor_serial #(
    parameter int DIGITS = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [4*DIGITS-1:0]   a_i,
    input  logic [4*DIGITS-1:0]   b_i,
    input  logic                  bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*DIGITS-1:0]   diff_o,
    output logic                  bout_o,
    output logic                  err_o
);

    localparam int W    = 4 * DIGITS;
    localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [W-1:0]      a_q, a_d, b_q, b_d, res_q, res_d, diff_q, diff_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              borrow_q, borrow_d, errin_q, errin_d;
    logic              busy_q, busy_d, done_q, done_d, bout_q, bout_d, err_q, err_d;

    logic [W-1:0]      a_sh_s, b_sh_s;
    logic [3:0]        a_dig_s, b_dig_s, dig_s;
    logic [5:0]        t_s, corr_s;
    logic              borrow_nxt_s;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (v[4*k +: 4] > 4'd9) begin
                bad = 1'b1;
            end else begin
                bad = bad;
            end
        end
        return bad;
    endfunction

    // State and datapath registers; synchronous reset aborts any operation in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            idx_q    <= '0;
            borrow_q <= 1'b0;
            errin_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            idx_q    <= idx_d;
            borrow_q <= borrow_d;
            errin_q  <= errin_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            diff_q   <= diff_d;
            bout_q   <= bout_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start_i ? S_RUN : S_IDLE;
            S_RUN:   state_d = (idx_q == LAST_IDX) ? S_FIN : S_RUN;
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One digit step: t = a - b - borrow in 6-bit two's complement, corrected by +10 on underflow.
    always_comb begin
        a_sh_s       = a_q >> {idx_q, 2'b00};
        b_sh_s       = b_q >> {idx_q, 2'b00};
        a_dig_s      = a_sh_s[3:0];
        b_dig_s      = b_sh_s[3:0];
        t_s          = {2'b00, a_dig_s} - {2'b00, b_dig_s} - {5'b00000, borrow_q};
        if (t_s[5]) begin
            corr_s       = t_s + 6'd10;
            borrow_nxt_s = 1'b1;
        end else begin
            corr_s       = t_s;
            borrow_nxt_s = 1'b0;
        end
        dig_s = corr_s[3:0];
    end

    // Datapath and registered-output next values per state.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        idx_d    = idx_q;
        borrow_d = borrow_q;
        errin_d  = errin_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        diff_d   = diff_q;
        bout_d   = bout_q;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    a_d      = a_i;
                    b_d      = b_i;
                    res_d    = '0;
                    idx_d    = '0;
                    borrow_d = bin_i;
                    errin_d  = has_bad_digit(a_i) | has_bad_digit(b_i);
                    busy_d   = 1'b1;
                    diff_d   = '0;
                    bout_d   = 1'b0;
                    err_d    = 1'b0;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            S_RUN: begin
                for (int k = 0; k < DIGITS; k++) begin
                    if (idx_q == IDXW'(k)) begin
                        res_d[4*k +: 4] = dig_s;
                    end else begin
                        res_d[4*k +: 4] = res_q[4*k +: 4];
                    end
                end
                borrow_d = borrow_nxt_s;
                idx_d    = idx_q + {{(IDXW-1){1'b0}}, 1'b1};
                busy_d   = 1'b1;
            end
            S_FIN: begin
                // Busy stays high through the done cycle, which the FSM spends back in IDLE.
                busy_d = 1'b1;
                done_d = 1'b1;
                diff_d = errin_q ? {W{1'b0}} : res_q;
                bout_d = errin_q ? 1'b0 : borrow_q;
                err_d  = errin_q;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign diff_o = diff_q;
    assign bout_o = bout_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_subtractor_serial.sv
// Scoreboard bench for bcd_subtractor_serial: stimulus pushes expected {diff,bout,err},
// a negedge monitor pops and compares on every done pulse.
module tb_bcd_subtractor_serial;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        bin;
    logic        busy, done, bout, err;
    logic [15:0] diff;

    logic [17:0] exp_q[$];
    int          total;
    int          bad;

    bcd_subtractor_serial #(.DIGITS(4)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .bin_i   (bin),
        .busy_o  (busy),
        .done_o  (done),
        .diff_o  (diff),
        .bout_o  (bout),
        .err_o   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got diff=%0h bout=%0b err=%0b expected no done",
                         diff, bout, err);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                check("diff", {16'h0, diff}, {16'h0, e[17:2]});
                check("bout", {31'h0, bout}, {31'h0, e[1]});
                check("err",  {31'h0, err},  {31'h0, e[0]});
            end
        end
    end

    // Called #1 after a clock edge; start is accepted at the next edge, returns #1 after it.
    task automatic start_op(input logic [15:0] av, input logic [15:0] bv, input logic bi,
                            input logic [15:0] ed, input logic eb, input logic ee, input bit push);
        a = av; b = bv; bin = bi; start = 1'b1;
        if (push) exp_q.push_back({ed, eb, ee});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (done === 1'b1) begin
                cyc = k;
                break;
            end
        end
        if (cyc < 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got no done expected done within 20 cycles");
        end
    endtask

    initial begin
        int cyc;
        total = 0; bad = 0;
        rst = 1'b1; start = 1'b0; a = 16'h0; b = 16'h0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_diff", {16'h0, diff}, 32'h0);
        check("rst_bout_err", {30'h0, bout, err}, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // T1: basic, latency and busy window
        start_op(16'h0042, 16'h0017, 1'b0, 16'h0025, 1'b0, 1'b0, 1'b1);
        check("t1_busy_after_start", {31'h0, busy}, 32'h1);
        wait_done(cyc);
        check("t1_latency", cyc, 32'd5);
        check("t1_busy_in_done", {31'h0, busy}, 32'h1);
        @(posedge clk); #1;
        check("t1_busy_after_done", {31'h0, busy}, 32'h0);
        check("t1_diff_held", {16'h0, diff}, 32'h0025);

        // T2: all-borrow wrap
        start_op(16'h0000, 16'h0001, 1'b0, 16'h9999, 1'b1, 1'b0, 1'b1);
        wait_done(cyc);
        @(posedge clk); #1;

        // T3: bin with equal operands, then back-to-back start in the done cycle
        start_op(16'h9999, 16'h9999, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1);
        wait_done(cyc);
        start_op(16'h9999, 16'h0000, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b1);
        check("t3_b2b_busy", {31'h0, busy}, 32'h1);
        wait_done(cyc);
        check("t3_b2b_latency", cyc, 32'd5);
        @(posedge clk); #1;

        // T4: invalid digit, then a clean op
        start_op(16'h00A3, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        wait_done(cyc);
        @(posedge clk); #1;
        start_op(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b1);
        wait_done(cyc);
        @(posedge clk); #1;

        // Extra patterns: mixed borrows, negative with trailing zeros
        start_op(16'h1234, 16'h0567, 1'b0, 16'h0667, 1'b0, 1'b0, 1'b1);
        wait_done(cyc);
        @(posedge clk); #1;
        start_op(16'h0100, 16'h0200, 1'b0, 16'h9900, 1'b1, 1'b0, 1'b1);
        wait_done(cyc);
        @(posedge clk); #1;

        // T5: start pulsed again mid-RUN is ignored
        start_op(16'h0050, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        start_op(16'h1111, 16'h0020, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        wait_done(cyc);
        repeat (8) @(posedge clk);
        #1;
        check("t5_busy_idle", {31'h0, busy}, 32'h0);
        check("t5_diff_held", {16'h0, diff}, 32'h0030);

        // T6: reset mid-RUN, with a same-cycle start, aborts the op
        start_op(16'h4321, 16'h1111, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        check("t6_busy", {31'h0, busy}, 32'h0);
        check("t6_done", {31'h0, done}, 32'h0);
        check("t6_diff", {16'h0, diff}, 32'h0);
        check("t6_bout_err", {30'h0, bout, err}, 32'h0);
        repeat (8) @(posedge clk);
        #1;
        check("t6_still_idle", {31'h0, busy}, 32'h0);
        start_op(16'h1000, 16'h0001, 1'b0, 16'h0999, 1'b0, 1'b0, 1'b1);
        wait_done(cyc);
        check("t6_latency", cyc, 32'd5);
        repeat (3) @(posedge clk);
        #1;

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
